// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared constants and types for the register-file write-back path.
// Source indices fix the slot each result unit occupies in the source buses.
package regfile_writeback_arbiter_pkg;
  localparam int NSRC       = 3;
  localparam int XLEN       = 32;
  localparam int NREGISTER  = 32;
  localparam int REG_IDX_W  = $clog2(NREGISTER);

  localparam int SRC_ALU    = 0;
  localparam int SRC_LOAD   = 1;
  localparam int SRC_MULDIV = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xdata_t;
endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Result-source handshake bundle: packed per-source valid/rd/data and one-hot ready.
// Source i occupies slice i of each packed bus.
interface regfile_writeback_arbiter_if;
  import regfile_writeback_arbiter_pkg::*;

  logic [NSRC-1:0]           src_valid;
  logic [NSRC*REG_IDX_W-1:0] src_rd;
  logic [NSRC*XLEN-1:0]      src_data;
  logic [NSRC-1:0]           src_ready;

  modport master (
    output src_valid,
    output src_rd,
    output src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_rd,
    input  src_data,
    output src_ready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr.
// ptr moves past the winner only when the caller signals advance.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  int            idx;

  // Scan farthest-first so the candidate nearest ptr overwrites the rest.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        ptr_nxt    = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_nxt;
    end
  end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU/load/mul-div results onto the single regfile write port
// and tracks outstanding destinations for decode RAW-hazard stalls.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  regfile_writeback_arbiter_if.slave src,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  input  logic     flush,
  input  reg_idx_t rs1_q,
  input  reg_idx_t rs2_q,
  output logic     hazard,
  output logic     write_enable_3,
  output reg_idx_t rd,
  output xdata_t   write_data_3
);
  logic [NSRC-1:0]      grant;
  logic                 accept;
  reg_idx_t             sel_rd;
  xdata_t               sel_data;
  logic [NREGISTER-1:0] pending;
  logic [NREGISTER-1:0] pending_nxt;

  // No grants while reset is held, independent of the pointer.
  rr_arbiter #(.N(NSRC)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (src.src_valid & {NSRC{rst}}),
    .advance (accept),
    .grant   (grant)
  );

  assign src.src_ready = grant;
  assign accept        = |grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        sel_rd   = src.src_rd[i*REG_IDX_W +: REG_IDX_W];
        sel_data = src.src_data[i*XLEN +: XLEN];
      end
    end
  end

  // Set applied after clear: a newer issue to the same rd stays pending.
  always_comb begin
    pending_nxt = pending;
    if (accept) pending_nxt[sel_rd] = 1'b0;
    if (flush) begin
      pending_nxt = '0;
    end else if (issue_valid && issue_rd != '0) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_enable_3 <= 1'b0;
      rd             <= '0;
      write_data_3   <= '0;
    end else begin
      write_enable_3 <= accept;
      if (accept) begin
        rd           <= sel_rd;
        write_data_3 <= sel_data;
      end
    end
  end

  assign hazard = pending[rs1_q] | pending[rs2_q];
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Table-driven bench for regfile_writeback_arbiter with a write-port scoreboard.
// Each table row is one clock cycle of stimulus plus expected ready/hazard.
module tb_regfile_writeback_arbiter;
  import regfile_writeback_arbiter_pkg::*;

  typedef struct {
    logic [2:0] v;
    logic [4:0] rd0, rd1, rd2;
    logic       iv;
    logic [4:0] ird;
    logic       fl;
    logic [4:0] rs1, rs2;
    logic [2:0] er;
    logic       eh;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  logic     clk;
  logic     rst;
  logic     issue_valid;
  reg_idx_t issue_rd;
  logic     flush;
  reg_idx_t rs1_q;
  reg_idx_t rs2_q;
  logic     hazard;
  logic     write_enable_3;
  reg_idx_t rd;
  xdata_t   write_data_3;

  regfile_writeback_arbiter_if intf ();

  regfile_writeback_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .src            (intf.slave),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .flush          (flush),
    .rs1_q          (rs1_q),
    .rs2_q          (rs2_q),
    .hazard         (hazard),
    .write_enable_3 (write_enable_3),
    .rd             (rd),
    .write_data_3   (write_data_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   passed = 0;
  int   total  = 0;
  int   cur    = -1;
  vec_t tbl[25];
  wr_t  exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec %0d: got %h want %h", nm, cur, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] rd0,
                              input logic [4:0] rd1, input logic [4:0] rd2,
                              input logic iv, input logic [4:0] ird,
                              input logic fl, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] er,
                              input logic eh);
    vec_t t;
    t.v = v; t.rd0 = rd0; t.rd1 = rd1; t.rd2 = rd2;
    t.iv = iv; t.ird = ird; t.fl = fl;
    t.rs1 = rs1; t.rs2 = rs2; t.er = er; t.eh = eh;
    return t;
  endfunction

  function automatic logic [31:0] dat(input int i, input int s);
    return 32'hDEADBEEF ^ {16'(i), 14'd0, 2'(s)};
  endfunction

  task automatic drive(input vec_t t, input int i);
    intf.src_valid = t.v;
    intf.src_rd    = {t.rd2, t.rd1, t.rd0};
    intf.src_data  = {dat(i, 2), dat(i, 1), dat(i, 0)};
    issue_valid    = t.iv;
    issue_rd       = t.ird;
    flush          = t.fl;
    rs1_q          = t.rs1;
    rs2_q          = t.rs2;
  endtask

  task automatic check_wport();
    wr_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("we", 32'(write_enable_3), 32'd1);
      chk("rd", 32'(rd), 32'(e.rd));
      chk("data", write_data_3, e.d);
    end else begin
      chk("we_idle", 32'(write_enable_3), 32'd0);
    end
  endtask

  task automatic push_exp(input vec_t t, input int i);
    wr_t e;
    for (int s = 0; s < NSRC; s++) begin
      if (t.er[s]) begin
        e.rd = (s == SRC_ALU) ? t.rd0 : (s == SRC_LOAD) ? t.rd1 : t.rd2;
        e.d  = dat(i, s);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_vec(input vec_t t, input int i);
    cur = i;
    drive(t, i);
    @(negedge clk);
    chk("src_ready", 32'(intf.src_ready), 32'(t.er));
    chk("hazard", 32'(hazard), 32'(t.eh));
    check_wport();
    push_exp(t, i);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    //            v      rd0 rd1 rd2 iv ird fl rs1 rs2 er   eh
    tbl[0]  = mk(3'b001,  5,  0,  0, 0,  0, 0,  0,  0, 3'b001, 0);
    tbl[1]  = idle;
    tbl[2]  = idle;
    tbl[3]  = mk(3'b100,  0,  0,  1, 0,  0, 0,  0,  0, 3'b100, 0);
    tbl[4]  = mk(3'b111, 10, 11, 12, 0,  0, 0,  0,  0, 3'b001, 0);
    tbl[5]  = mk(3'b111, 13, 11, 12, 0,  0, 0,  0,  0, 3'b010, 0);
    tbl[6]  = mk(3'b111, 13, 14, 12, 0,  0, 0,  0,  0, 3'b100, 0);
    tbl[7]  = mk(3'b111, 13, 14, 15, 0,  0, 0,  0,  0, 3'b001, 0);
    tbl[8]  = idle;
    tbl[9]  = mk(3'b000,  0,  0,  0, 1,  7, 0,  7,  0, 3'b000, 0);
    tbl[10] = mk(3'b000,  0,  0,  0, 0,  0, 0,  7,  0, 3'b000, 1);
    tbl[11] = mk(3'b010,  0,  7,  0, 0,  0, 0,  7,  0, 3'b010, 1);
    tbl[12] = mk(3'b000,  0,  0,  0, 0,  0, 0,  7,  0, 3'b000, 0);
    tbl[13] = mk(3'b001,  9,  0,  0, 1,  9, 0,  9,  0, 3'b001, 0);
    tbl[14] = mk(3'b000,  0,  0,  0, 1,  0, 0,  9,  0, 3'b000, 1);
    tbl[15] = mk(3'b000,  0,  0,  0, 0,  0, 0,  9,  7, 3'b000, 1);
    tbl[16] = mk(3'b000,  0,  0,  0, 1,  3, 0,  9,  0, 3'b000, 1);
    tbl[17] = mk(3'b000,  0,  0,  0, 1,  4, 0,  3,  0, 3'b000, 1);
    tbl[18] = mk(3'b100,  0,  0,  3, 1, 12, 1,  4,  9, 3'b100, 1);
    tbl[19] = mk(3'b000,  0,  0,  0, 0,  0, 0,  3,  4, 3'b000, 0);
    tbl[20] = mk(3'b000,  0,  0,  0, 0,  0, 0,  9, 12, 3'b000, 0);
    tbl[21] = mk(3'b011, 20, 21,  0, 0,  0, 0,  0,  0, 3'b001, 0);
    tbl[22] = mk(3'b011, 22, 21,  0, 0,  0, 0,  0,  0, 3'b010, 0);
    tbl[23] = mk(3'b011, 22, 23,  0, 0,  0, 0,  0,  0, 3'b001, 0);
    tbl[24] = idle;

    rst = 1'b0;
    drive(idle, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(write_enable_3), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data", write_data_3, 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 25; i++) run_vec(tbl[i], i);

    // Reset asserted mid-cycle with all sources requesting and a pending rd.
    cur = 100;
    run_vec(mk(3'b111, 1, 2, 3, 1, 15, 0, 15, 0, 3'b010, 0), 100);
    cur = 101;
    drive(mk(3'b111, 1, 2, 3, 0, 0, 0, 15, 0, 3'b000, 0), 101);
    #1;
    chk("pre_rst_hazard", 32'(hazard), 32'd1);
    chk("pre_rst_we", 32'(write_enable_3), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_we", 32'(write_enable_3), 32'd0);
    chk("async_rd", 32'(rd), 32'd0);
    chk("async_data", write_data_3, 32'd0);
    chk("async_ready", 32'(intf.src_ready), 32'd0);
    chk("async_hazard", 32'(hazard), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_vec(mk(3'b111, 1, 2, 3, 0, 0, 0, 15, 0, 3'b001, 0), 102);
    run_vec(idle, 103);
    run_vec(idle, 104);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
